// File: rtl/imm_pkg.sv
// imm_pkg: opcode, immediate-format and skid-state definitions shared by the immediate generator
package imm_pkg;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;
  typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_TWO} skid_state_e;
endpackage

// File: rtl/imm_decode_comb.sv
// imm_decode_comb: combinational RV32I/RV64I immediate decoder; IMM_ILLEGAL_EN adds the illegal flag
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst_i,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      fmt_o
`ifdef IMM_ILLEGAL_EN
  , output logic          illegal_o
`endif
);
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        opimm32;
  logic        opimm;
  logic        shift;
  logic        wide_sh;
  logic [2:0]  fmt_raw;
  logic [31:0] imm32;
  always_comb begin
    opc     = inst_i[6:0];
    f3      = inst_i[14:12];
    opimm32 = (XLEN == 64) && (opc == OPC_OPIMM32);
    opimm   = (opc == OPC_OPIMM) || opimm32;
    shift   = opimm && (f3 == F3_SLL || f3 == F3_SR);
    // only 64-bit OP-IMM shifts use a 6-bit shamt; the word forms stay at 5 bits
    wide_sh = (XLEN == 64) && (opc == OPC_OPIMM);
    fmt_raw = shift ? FMT_SHAMT :
              (opimm || opc == OPC_LOAD || opc == OPC_JALR || opc == OPC_SYSTEM) ? FMT_I :
              (opc == OPC_STORE) ? FMT_S :
              (opc == OPC_BRANCH) ? FMT_B :
              (opc == OPC_LUI || opc == OPC_AUIPC) ? FMT_U :
              (opc == OPC_JAL) ? FMT_J : FMT_NONE;
    imm32   = (fmt_raw == FMT_I) ? {{20{inst_i[31]}}, inst_i[31:20]} :
              (fmt_raw == FMT_S) ? {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]} :
              (fmt_raw == FMT_B) ? {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0} :
              (fmt_raw == FMT_U) ? {inst_i[31:12], 12'b0} :
              (fmt_raw == FMT_J) ? {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0} :
              (fmt_raw == FMT_SHAMT) ? {26'b0, wide_sh & inst_i[25], inst_i[24:20]} : 32'b0;
  end
`ifdef IMM_ILLEGAL_EN
  assign illegal_o = (fmt_raw == FMT_NONE) || (inst_i[1:0] != 2'b11) ||
                     ((XLEN == 32) && shift && inst_i[25]);
  assign fmt_o     = illegal_o ? FMT_NONE : fmt_raw;
  assign imm_o     = illegal_o ? '0 : XLEN'($signed(imm32));
`else
  assign fmt_o     = fmt_raw;
  assign imm_o     = XLEN'($signed(imm32));
`endif
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate decoder behind a 2-entry valid/ready skid buffer
// IMM_ILLEGAL_EN adds out_illegal, registered alongside each entry
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag
`ifdef IMM_ILLEGAL_EN
  , output logic           out_illegal
`endif
);
`ifdef IMM_ILLEGAL_EN
  localparam int PW = XLEN + 3 + TAG_W + 1;
`else
  localparam int PW = XLEN + 3 + TAG_W;
`endif
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic [PW-1:0]   dec_pl;
  logic [PW-1:0]   main_q, main_d, skid_q, skid_d;
  logic            rdy_q, rdy_d;
  logic            acc, drn;
  skid_state_e     state_q, state_d;
`ifdef IMM_ILLEGAL_EN
  logic            dec_ill;
  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .inst_i(in_inst), .imm_o(dec_imm), .fmt_o(dec_fmt), .illegal_o(dec_ill)
  );
  assign dec_pl = {dec_ill, dec_imm, dec_fmt, in_tag};
  assign {out_illegal, out_imm, out_fmt, out_tag} = main_q;
`else
  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .inst_i(in_inst), .imm_o(dec_imm), .fmt_o(dec_fmt)
  );
  assign dec_pl = {dec_imm, dec_fmt, in_tag};
  assign {out_imm, out_fmt, out_tag} = main_q;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SKID_EMPTY;
      rdy_q   <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end
  always_comb begin
    acc     = in_valid & rdy_q;
    drn     = out_valid & out_ready;
    state_d = flush ? SKID_EMPTY :
              (state_q == SKID_EMPTY) ? (acc ? SKID_ONE : SKID_EMPTY) :
              (state_q == SKID_ONE) ? ((acc & ~drn) ? SKID_TWO : (~acc & drn) ? SKID_EMPTY : SKID_ONE) :
              (drn ? SKID_ONE : SKID_TWO);
    // accept-with-drain in ONE overwrites main directly so the stream never stalls
    main_d  = (state_q == SKID_TWO) ? (drn ? skid_q : main_q) :
              (acc & ((state_q == SKID_EMPTY) | drn)) ? dec_pl : main_q;
    skid_d  = ((state_q == SKID_ONE) & acc & ~drn) ? dec_pl : skid_q;
    rdy_d   = (state_d != SKID_TWO);
  end
  always_comb begin
    out_valid = (state_q != SKID_EMPTY);
    in_ready  = rdy_q;
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed and randomized checks of imm_gen_pipe against a queue-based reference
module tb_imm_gen_pipe;
  import imm_pkg::*;
  localparam int XLEN  = 32;
  localparam int TAG_W = 8;
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      in_inst = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             in_ready, out_valid;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic [TAG_W-1:0] out_tag;
`ifdef IMM_ILLEGAL_EN
  logic             out_illegal;
`endif
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  imm_gen_pipe #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_tag(out_tag)
`ifdef IMM_ILLEGAL_EN
    , .out_illegal(out_illegal)
`endif
  );
  typedef struct {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } ent_t;
  ent_t q[$];
  logic exp_ready = 1'b0;
  function automatic longint sx(input longint v, input int bits);
    return ((v >> (bits - 1)) & 1) != 0 ? v - (longint'(1) << bits) : v;
  endfunction
  function automatic ent_t ref_ent(input logic [31:0] inst, input logic [TAG_W-1:0] tag);
    ent_t e;
    longint w, v;
    logic [63:0] u;
    bit sh_op, ill;
    w = longint'({32'b0, inst});
    sh_op = (inst[14:12] == 3'd1) || (inst[14:12] == 3'd5);
    v = 0;
    ill = 1'b0;
    e.fmt = FMT_NONE;
    case (inst[6:0])
      OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin e.fmt = FMT_I; v = sx(w >> 20, 12); end
      OPC_OPIMM:
        if (sh_op) begin
          e.fmt = FMT_SHAMT;
          v = (w >> 20) & (XLEN == 64 ? 63 : 31);
          ill = (XLEN == 32) && inst[25];
        end else begin e.fmt = FMT_I; v = sx(w >> 20, 12); end
      OPC_OPIMM32:
        if (XLEN == 64) begin
          e.fmt = sh_op ? FMT_SHAMT : FMT_I;
          v = sh_op ? ((w >> 20) & 31) : sx(w >> 20, 12);
        end
      OPC_STORE:  begin e.fmt = FMT_S; v = sx(((w >> 25) << 5) | ((w >> 7) & 31), 12); end
      OPC_BRANCH: begin
        e.fmt = FMT_B;
        v = sx(((w >> 31) << 12) | (((w >> 7) & 1) << 11) | (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1), 13);
      end
      OPC_LUI, OPC_AUIPC: begin e.fmt = FMT_U; v = sx(w & 64'hFFFFF000, 32); end
      OPC_JAL: begin
        e.fmt = FMT_J;
        v = sx(((w >> 31) << 20) | (((w >> 12) & 255) << 12) | (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1), 21);
      end
      default: ;
    endcase
`ifdef IMM_ILLEGAL_EN
    ill = ill || (e.fmt == FMT_NONE) || (inst[1:0] != 2'b11);
    if (ill) begin e.fmt = FMT_NONE; v = 0; end
`else
    ill = 1'b0;
`endif
    u = v;
    e.imm = u[XLEN-1:0];
    e.tag = tag;
    e.ill = ill;
    return e;
  endfunction
  // reference occupancy: a plain FIFO of at most two decoded entries
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      exp_ready <= 1'b0;
    end else if (flush) begin
      q.delete();
      exp_ready <= 1'b1;
    end else begin
      if (q.size() != 0 && out_ready) void'(q.pop_front());
      if (in_valid && exp_ready) q.push_back(ref_ent(in_inst, in_tag));
      exp_ready <= (q.size() < 2);
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", in_ready); end
    tests++; if ({out_imm, out_fmt, out_tag} !== '0) begin fails++; $display("FAIL reset_payload: got %h/%0d/%h want 0", out_imm, out_fmt, out_tag); end
    reset = 1'b0;
    tick;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_valid: got %b want 0", out_valid); end
  endtask
  task automatic test_addi;
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_tag = 8'h11;
    tick;
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    tests++; if (out_imm !== {XLEN{1'b1}}) begin fails++; $display("FAIL addi_imm: got %h want all ones", out_imm); end
    tests++; if (out_fmt !== FMT_I) begin fails++; $display("FAIL addi_fmt: got %0d want %0d", out_fmt, FMT_I); end
    tests++; if (out_tag !== 8'h11) begin fails++; $display("FAIL addi_tag: got %h want 11", out_tag); end
    tick;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL addi_drain: got %b want 0", out_valid); end
  endtask
  task automatic test_back_to_back;
    logic [31:0] insts [4] = '{32'hFE112E23, 32'hFE000CE3, 32'h123450B7, 32'h001000EF};
    longint      imms  [4] = '{-4, -8, 64'h12345000, 64'h800};
    logic [2:0]  fmts  [4] = '{FMT_S, FMT_B, FMT_U, FMT_J};
    logic [63:0] u;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_inst = insts[i]; in_tag = 8'h20 + 8'(i);
      tick;
      u = imms[i];
      tests++;
      if (out_valid !== 1'b1 || out_imm !== u[XLEN-1:0] || out_fmt !== fmts[i] || out_tag !== 8'h20 + 8'(i)) begin
        fails++;
        $display("FAIL b2b_%0d: got v=%b imm=%h fmt=%0d tag=%h want v=1 imm=%h fmt=%0d tag=%h",
                 i, out_valid, out_imm, out_fmt, out_tag, u[XLEN-1:0], fmts[i], 8'h20 + 8'(i));
      end
    end
    in_valid = 1'b0;
    tick;
  endtask
  task automatic test_shamt;
    ent_t e;
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'h4030D093; in_tag = 8'h30;
    tick;
    in_valid = 1'b0;
    tests++; if (out_imm !== XLEN'(3)) begin fails++; $display("FAIL srai_imm: got %h want 3", out_imm); end
    tests++; if (out_fmt !== FMT_SHAMT) begin fails++; $display("FAIL srai_fmt: got %0d want %0d", out_fmt, FMT_SHAMT); end
    in_valid = 1'b1; in_inst = 32'h02309093; in_tag = 8'h31;
    e = ref_ent(in_inst, in_tag);
    tick;
    in_valid = 1'b0;
    tests++; if (out_imm !== e.imm || out_fmt !== e.fmt) begin fails++; $display("FAIL slli_bit25: got %h/%0d want %h/%0d", out_imm, out_fmt, e.imm, e.fmt); end
    tick;
  endtask
  task automatic test_backpressure;
    int got[$];
    bit will_acc;
    out_ready = 1'b0;
    in_inst = 32'h00100093;
    in_valid = 1'b1; in_tag = 8'd1;
    tick;
    in_tag = 8'd2;
    tick;
    in_tag = 8'd3;
    tests++; if (in_ready !== 1'b0 || out_tag !== 8'd1 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_full: got rdy=%b tag=%0d v=%b want rdy=0 tag=1 v=1", in_ready, out_tag, out_valid); end
    repeat (3) begin
      tick;
      tests++; if (in_ready !== 1'b0 || out_tag !== 8'd1) begin fails++; $display("FAIL bp_hold: got rdy=%b tag=%0d want rdy=0 tag=1", in_ready, out_tag); end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      will_acc = in_valid && in_ready;
      if (out_valid) got.push_back(int'(out_tag));
      tick;
      if (will_acc) in_valid = 1'b0;
    end
    tests++; if (got.size() != 3) begin fails++; $display("FAIL bp_count: got %0d want 3", got.size()); end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      tests++; if (got[i] != i + 1) begin fails++; $display("FAIL bp_order_%0d: got %0d want %0d", i, got[i], i + 1); end
    end
  endtask
  task automatic test_flush;
    out_ready = 1'b0;
    in_inst = 32'h00500093;
    in_valid = 1'b1; in_tag = 8'h40;
    tick;
    in_tag = 8'h41;
    tick;
    tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL flush_fill: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready); end
    flush = 1'b1; in_tag = 8'h42;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_two: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
    in_valid = 1'b1; in_tag = 8'h43;
    tick;
    in_tag = 8'h44; flush = 1'b1;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_one_acc: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
    out_ready = 1'b1;
    repeat (3) begin
      tick;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_ghost: got v=%b tag=%h want v=0", out_valid, out_tag); end
    end
  endtask
  task automatic test_reset_mid;
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hFE112E23; in_tag = 8'h55;
    tick;
    in_tag = 8'h56;
    tick;
    reset = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin fails++; $display("FAIL midrst_flags: got v=%b rdy=%b want 0/0", out_valid, in_ready); end
    tests++; if ({out_imm, out_fmt, out_tag} !== '0) begin fails++; $display("FAIL midrst_payload: got %h/%0d/%h want 0", out_imm, out_fmt, out_tag); end
    tick;
    reset = 1'b0; in_valid = 1'b0;
    tick;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL midrst_recover: got rdy=%b v=%b want 1/0", in_ready, out_valid); end
  endtask
`ifdef IMM_ILLEGAL_EN
  task automatic test_illegal;
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'h0000007F; in_tag = 8'h60;
    tick;
    in_inst = 32'h02009093; in_tag = 8'h61;
    tests++; if (out_illegal !== 1'b1 || out_imm !== '0 || out_fmt !== FMT_NONE) begin fails++; $display("FAIL illegal_opc: got ill=%b imm=%h fmt=%0d want 1/0/0", out_illegal, out_imm, out_fmt); end
    tick;
    in_valid = 1'b0;
    tests++; if (out_illegal !== 1'b1 || out_fmt !== FMT_NONE) begin fails++; $display("FAIL illegal_shift25: got ill=%b fmt=%0d want 1/0", out_illegal, out_fmt); end
    tick;
  endtask
`endif
  task automatic test_random;
    logic [6:0] ops [10] = '{OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_STORE, OPC_BRANCH,
                             OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_SYSTEM};
    logic [31:0] r;
    for (int c = 0; c < 400; c++) begin
      tests++; if (out_valid !== (q.size() != 0)) begin fails++; $display("FAIL rnd_valid @%0d: got %b want %b", c, out_valid, q.size() != 0); end
      tests++; if (in_ready !== exp_ready) begin fails++; $display("FAIL rnd_ready @%0d: got %b want %b", c, in_ready, exp_ready); end
      if (q.size() != 0) begin
        tests++;
        if (out_imm !== q[0].imm || out_fmt !== q[0].fmt || out_tag !== q[0].tag) begin
          fails++;
          $display("FAIL rnd_payload @%0d: got %h/%0d/%h want %h/%0d/%h", c, out_imm, out_fmt, out_tag, q[0].imm, q[0].fmt, q[0].tag);
        end
`ifdef IMM_ILLEGAL_EN
        tests++; if (out_illegal !== q[0].ill) begin fails++; $display("FAIL rnd_illegal @%0d: got %b want %b", c, out_illegal, q[0].ill); end
`endif
      end
      r = $urandom;
      if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 9)];
      in_inst   = r;
      in_tag    = 8'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick;
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask
  initial begin
    test_reset;
    test_addi;
    test_back_to_back;
    test_shamt;
    test_backpressure;
    test_flush;
    test_reset_mid;
`ifdef IMM_ILLEGAL_EN
    test_illegal;
`endif
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
